bcd_counter_chain: RTL and testbench
====================================

// Module: bcd_counter_chain
// PURPOSE
//   Cascaded decade (BCD) counter feeding the 7-segment scan driver. Produces a packed
//   BCD value q, one nibble per digit, least-significant digit in q[3:0].
//   The display stage shows the top three nibbles, q[31:20], when DIGITS=8.
//   An internal prescaler divides clk down to the count rate.
//   Provides synchronous clear, parallel load and a terminal carry pulse for further chaining.
// PARAMETERS
//   DIGITS    8           number of BCD digits; q width = 4*DIGITS
//   PRESCALE  50_000_000  clk cycles per count step (>=1); 1 = count every enabled cycle
// PORTS
//   clk       in   1          system clock, rising edge
//   rst_n     in   1          reset; asynchronous, active-low
//   en        in   1          count enable; 0 freezes prescaler and q
//   clr       in   1          synchronous clear
//   load      in   1          synchronous parallel load
//   load_val  in   4*DIGITS   BCD value to load
//   dir       in   1          0=up, 1=down (present only with BCD_DOWN_COUNT_EN)
//   q         out  4*DIGITS   packed BCD count, registered
//   tick      out  1          one-cycle pulse per count step, registered
//   co        out  1          one-cycle carry/borrow pulse on full wrap, registered
// BEHAVIOUR
//   - Reset (rst_n=0, async): q=0, tick=0, co=0, prescaler=0. Takes effect immediately,
//     including mid-count.
//   - Prescaler:
//     - counts 0..PRESCALE-1 while en=1.
//     - tc = en && (pre==PRESCALE-1); pre wraps to 0 on tc.
//     - en=0 holds pre and q; tick=0, co=0.
//   - Latency: on the edge where tc=1, q takes its stepped value and tick=1 for that one cycle.
//     tick is therefore aligned with the new q.
//   - Up step: digit 0 += 1. Digit i steps iff digits 0..i-1 are all 9. A stepped 9 becomes 0.
//   - Full wrap: when q goes 99..9 -> 00..0, co=1 in the same cycle as the wrapped q.
//     Otherwise co=0.
//   - Priority, evaluated per edge: clr > load > step.
//     - clr: q=0, pre=0, tick=0, co=0.
//     - load: q=load_val. Any nibble >9 is loaded as 0. pre keeps running.
//       If tc also fires, tick=1, no step, co=0.
//   - q nibbles never hold values >9.
// CONFIGURATION
//   BCD_DOWN_COUNT_EN defined:
//     - dir port exists; dir=1 decrements.
//     - digit i steps iff lower digits are all 0; a stepped 0 becomes 9.
//     - 00..0 -> 99..9 raises co (borrow) for one cycle.
//     - dir sampled on the tc edge only.
//   BCD_DOWN_COUNT_EN undefined: no dir port; up-count only; behaviour as above.
// STRUCTURE
//   - Package bcd_pkg:
//     - BCD_MAX = 4'd9, BCD_MIN = 4'd0
//     - typedef bcd_digit_t (logic [3:0])
//     - function bcd_sanitize (nibble >9 -> 0)
//   - Sub-module bcd_digit: one decade cell.
//     - inputs: step, dir, load, load_d, clr
//     - outputs: d, at_term (d==9 up / d==0 down)
//   - Top: prescaler plus generate loop of DIGITS bcd_digit instances.
//     - step[i] = tc & &at_term[i-1:0]
//     - co = registered &at_term & tc, cleared by load/clr
// TESTING
//   - PRESCALE=4, en=1 after reset:
//     - tick every 4th cycle
//     - q 0x00000000 -> 0x00000001 -> 0x00000002
//     - co=0 throughout
//   - PRESCALE=1:
//     - load 0x00000998 -> q=0x00000998
//     - next two ticks -> 0x00000999, 0x00001000
//   - PRESCALE=1:
//     - load 0x99999998 -> two ticks -> 0x99999999, then 0x00000000
//     - co=1 for exactly that one cycle
//   - en=0 for 10 cycles mid-count: q and prescaler hold; tick=0; resume exactly where stopped.
//   - clr and load same cycle (load_val=0x12345678): q=0x00000000.
//   - load 0x0000A0F5: q=0x00000005. Then assert rst_n=0 mid-count: q=0 before next clk edge.
//   - BCD_DOWN_COUNT_EN, dir=1, PRESCALE=1:
//     - load 0 -> tick -> q=0x99999999, co=1
//     - next tick -> q=0x99999998

Source files
------------

// File: rtl/bcd_pkg.sv
// ============================================================================
// Package : bcd_pkg
// Brief   : Shared types, constants and helpers for the BCD counter chain.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef logic [3:0] bcd_digit_t;

  // Any nibble that is not a legal decimal digit collapses to zero.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t nib);
    return (nib > BCD_MAX) ? BCD_MIN : nib;
  endfunction

endpackage : bcd_pkg

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// Module  : bcd_digit
// Brief   : One decade cell. Holds a single BCD digit, steps up or down on
//           request and flags when it sits at its terminal value (9 counting
//           up, 0 counting down) so the next cell can be enabled.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  bcd_digit_t load_d,
  input  logic       step,
  input  logic       dir,
  output bcd_digit_t d,
  output logic       at_term
);

  bcd_digit_t r_d;

  // Digit register: clear beats load beats step; wraps 9->0 up and 0->9 down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d <= BCD_MIN;
    end else if (clr) begin
      r_d <= BCD_MIN;
    end else if (load) begin
      r_d <= bcd_sanitize(load_d);
    end else if (step) begin
      if (dir) begin
        r_d <= (r_d == BCD_MIN) ? BCD_MAX : (r_d - 4'd1);
      end else begin
        r_d <= (r_d == BCD_MAX) ? BCD_MIN : (r_d + 4'd1);
      end
    end
  end

  assign d       = r_d;
  assign at_term = dir ? (r_d == BCD_MIN) : (r_d == BCD_MAX);

endmodule : bcd_digit

`default_nettype wire

// File: rtl/bcd_counter_chain.sv
// ============================================================================
// Module  : bcd_counter_chain
// Brief   : Cascaded decade counter with a clock prescaler, synchronous clear,
//           parallel load, a per-step tick and a full-wrap carry/borrow pulse.
//           Define BCD_DOWN_COUNT_EN to add the dir port (1 = count down).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_counter_chain
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int PRESCALE = 50_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
`ifdef BCD_DOWN_COUNT_EN
  input  logic                dir,
`endif
  output logic [4*DIGITS-1:0] q,
  output logic                tick,
  output logic                co
);

  // A one-cycle prescale still needs a 1-bit register to keep widths legal.
  localparam int c_pre_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESCALE - 1);

  logic [c_pre_w-1:0] r_pre;
  logic               r_tick;
  logic               r_co;
  logic               w_tc;
  logic               w_dir;
  logic [DIGITS:0]    w_carry;
  logic [DIGITS-1:0]  w_at_term;

`ifdef BCD_DOWN_COUNT_EN
  assign w_dir = dir;
`else
  assign w_dir = 1'b0;
`endif

  assign w_tc = en && (r_pre == c_pre_last);

  // Prescaler: free-runs while enabled, frozen otherwise, zeroed by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (clr) begin
      r_pre <= '0;
    end else if (en) begin
      r_pre <= w_tc ? '0 : (r_pre + c_pre_w'(1));
    end
  end

  // Ripple enable: a digit steps only when every lower digit is terminal.
  assign w_carry[0] = w_tc;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit u_digit (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .load    (load),
      .load_d  (load_val[4*gi +: 4]),
      .step    (w_carry[gi]),
      .dir     (w_dir),
      .d       (q[4*gi +: 4]),
      .at_term (w_at_term[gi])
    );
    assign w_carry[gi+1] = w_carry[gi] & w_at_term[gi];
  end

  // Status pulses: tick marks every step slot, co marks a full wrap of q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= 1'b0;
      r_co   <= 1'b0;
    end else if (clr) begin
      r_tick <= 1'b0;
      r_co   <= 1'b0;
    end else begin
      r_tick <= w_tc;
      r_co   <= load ? 1'b0 : w_carry[DIGITS];
    end
  end

  assign tick = r_tick;
  assign co   = r_co;

endmodule : bcd_counter_chain

`default_nettype wire

// File: tb/tb_bcd_counter_chain.sv
// ============================================================================
// Module  : tb_bcd_counter_chain
// Brief   : Drives two counters (PRESCALE=4 and PRESCALE=1) with shared
//           stimulus and compares them against a decimal-arithmetic model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_counter_chain;

  localparam int DIGITS = 8;
  localparam int MODV   = 100_000_000;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic        load;
  logic [31:0] load_val;
  logic        dir;
  logic [31:0] q4, q1;
  logic        tick4, tick1, co4, co1;

  int n_tests;
  int n_fail;

  // Reference state per instance: 0 -> PRESCALE=4, 1 -> PRESCALE=1.
  int m_val  [2];
  int m_pre  [2];
  int m_tick [2];
  int m_co   [2];
  int m_ps   [2];

  bcd_counter_chain #(.DIGITS(DIGITS), .PRESCALE(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
`ifdef BCD_DOWN_COUNT_EN
    .dir      (dir),
`endif
    .q        (q4),
    .tick     (tick4),
    .co       (co4)
  );

  bcd_counter_chain #(.DIGITS(DIGITS), .PRESCALE(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
`ifdef BCD_DOWN_COUNT_EN
    .dir      (dir),
`endif
    .q        (q1),
    .tick     (tick1),
    .co       (co1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int bcd_to_int(input logic [31:0] x);
    int v = 0;
    int w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      int nib = int'(x[4*i +: 4]);
      if (nib > 9) nib = 0;
      v += nib * w;
      w *= 10;
    end
    return v;
  endfunction

  function automatic logic [31:0] int_to_bcd(input int v);
    logic [31:0] x = '0;
    int r = v;
    for (int i = 0; i < DIGITS; i++) begin
      x[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return x;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_val[m] = 0; m_pre[m] = 0; m_tick[m] = 0; m_co[m] = 0;
    end
  endtask

  // Advance the reference by one rising edge using the inputs now applied.
  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      bit tc;
      tc = en && (m_pre[m] == m_ps[m] - 1);
      if (clr) begin
        m_val[m] = 0; m_pre[m] = 0; m_tick[m] = 0; m_co[m] = 0;
      end else begin
        if (en) m_pre[m] = tc ? 0 : m_pre[m] + 1;
        m_tick[m] = tc ? 1 : 0;
        m_co[m]   = 0;
        if (load) begin
          m_val[m] = bcd_to_int(load_val);
        end else if (tc) begin
`ifdef BCD_DOWN_COUNT_EN
          if (dir) begin
            if (m_val[m] == 0) m_co[m] = 1;
            m_val[m] = (m_val[m] + MODV - 1) % MODV;
          end else
`endif
          begin
            if (m_val[m] == MODV - 1) m_co[m] = 1;
            m_val[m] = (m_val[m] + 1) % MODV;
          end
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".q4"},    q4,           int_to_bcd(m_val[0]));
    chk({tag, ".tick4"}, 32'(tick4),   32'(m_tick[0]));
    chk({tag, ".co4"},   32'(co4),     32'(m_co[0]));
    chk({tag, ".q1"},    q1,           int_to_bcd(m_val[1]));
    chk({tag, ".tick1"}, 32'(tick1),   32'(m_tick[1]));
    chk({tag, ".co1"},   32'(co1),     32'(m_co[1]));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic do_load(input string tag, input logic [31:0] v);
    load = 1'b1; load_val = v;
    cycle(tag);
    load = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    m_ps[0] = 4; m_ps[1] = 1;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; dir = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;

    // Plain up-count from reset: PRESCALE=4 ticks every fourth edge.
    en = 1'b1;
    run("count", 12);

    // Decade ripple across a digit boundary.
    do_load("ld998", 32'h0000_0998);
    chk("ld998.q1", q1, 32'h0000_0998);
    run("ripple", 2);
    chk("ripple.q1", q1, 32'h0000_1000);

    // Full wrap with carry pulse.
    do_load("ldwrap", 32'h9999_9998);
    run("wrap", 2);
    chk("wrap.q1", q1, 32'h0000_0000);
    chk("wrap.co1", 32'(co1), 32'd1);
    run("postwrap", 2);

    // Freeze mid-count and resume.
    run("prefreeze", 3);
    en = 1'b0;
    run("freeze", 10);
    en = 1'b1;
    run("resume", 6);

    // Clear dominates a simultaneous load.
    clr = 1'b1; load = 1'b1; load_val = 32'h1234_5678;
    cycle("clrld");
    clr = 1'b0; load = 1'b0;
    chk("clrld.q1", q1, 32'h0000_0000);
    run("afterclr", 3);

    // Illegal nibbles load as zero, then asynchronous reset mid-cycle.
    do_load("ldbad", 32'h0000_A0F5);
    chk("ldbad.q1", q1, 32'h0000_0005);
    run("prereset", 2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async.q4", q4, 32'h0);
    chk("async.q1", q1, 32'h0);
    chk("async.tick1", 32'(tick1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("postreset", 5);

`ifdef BCD_DOWN_COUNT_EN
    // Down-count borrow through zero.
    dir = 1'b1;
    do_load("ldzero", 32'h0);
    run("down", 1);
    chk("down.q1", q1, 32'h9999_9999);
    chk("down.co1", 32'(co1), 32'd1);
    run("down2", 1);
    chk("down2.q1", q1, 32'h9999_9998);
    dir = 1'b0;
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 99) < 85);
      clr  = ($urandom_range(0, 99) < 3);
      load = ($urandom_range(0, 99) < 8);
      case ($urandom_range(0, 3))
        0:       load_val = $urandom;
        1:       load_val = 32'h9999_9990 | 32'($urandom_range(7, 9));
        2:       load_val = 32'h0000_0000 | 32'($urandom_range(0, 2));
        default: load_val = int_to_bcd($urandom_range(0, MODV - 1));
      endcase
`ifdef BCD_DOWN_COUNT_EN
      dir = $urandom_range(0, 1) == 1;
`endif
      cycle("rand");
    end
    clr = 1'b0; load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bcd_counter_chain

`default_nettype wire
